// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, MSB-first RX/TX shifters, one-word TX buffer.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release miso (1'bz) outside an active transfer.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_d, cs_d;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CNT_W-1:0]  bit_cnt;
    logic              word_done;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_buf;

    logic start, rise_ev, fall_ev, next_load, shift_ev, consume, last_bit;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign rx_next  = {rx_shift, mosi_s};
    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

    // Bring the asynchronous pins into the clk domain and keep a delayed copy for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle transfer events; a cs rise masks any sclk edge.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        rise_ev   = 1'b0;
        fall_ev   = 1'b0;
        next_load = 1'b0;
        shift_ev  = 1'b0;
        consume   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else begin
                    rise_ev = sclk_rise;
                    fall_ev = sclk_fall;
                end
            end
            default: state_d = IDLE;
        endcase
        next_load = fall_ev && (bit_cnt == '0) && word_done;
        shift_ev  = fall_ev && (bit_cnt != '0);
        consume   = start || next_load;
    end

    // TX buffer, TX/RX shifters, bit counter and the one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (consume) begin
                tx_shift    <= tx_ready ? '0 : tx_buf;
                tx_underrun <= tx_ready;
            end else if (shift_ev) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (tx_load && (tx_ready || consume)) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (consume) begin
                tx_ready <= 1'b1;
            end

            if (rise_ev) begin
                rx_shift <= rx_next[DATA_W-2:0];
                if (last_bit) begin
                    rx_data   <= rx_next;
                    rx_valid  <= 1'b1;
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (next_load) begin
                word_done <= 1'b0;
            end

            if (start || (state_q == ACTIVE && cs_rise)) begin
                bit_cnt   <= '0;
                word_done <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = (state_q == ACTIVE) ? tx_shift[DATA_W-1] : 1'bz;
`else
    assign miso = (state_q == ACTIVE) ? tx_shift[DATA_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master drives directed and random transfers and
// a transaction-level model (one-entry buffer, word lists, pulse counts) predicts results.
module tb_spi_slave;

    localparam int SYNC = 2;
    localparam int H    = SYNC + 3;

    logic       clk, rst, sclk, cs, mosi, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_load, tx_ready, rx_valid, tx_underrun;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    spi_slave #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rv = 0;
    int n_un = 0;
    int last_rv_cyc = 0;
    int last_rise = 0;

    bit         m_full = 1'b0;
    logic [7:0] m_buf = 8'h00;
    int         exp_rv = 0;
    int         exp_un = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Count cycles in which each pulse output is high.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_rv <= n_rv + 1;
                last_rv_cyc <= cyc;
            end
            if (tx_underrun) n_un <= n_un + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    task automatic tb_load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = d;
        end
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Model of a buffer consume: the buffered word, or zero plus an underrun.
    task automatic consume(output logic [7:0] w);
        if (m_full) begin
            w = m_buf;
            m_full = 1'b0;
        end else begin
            w = 8'h00;
            exp_un++;
        end
    endtask

    task automatic do_word(input logic [7:0] mo, input int nb, input bit ld_mid,
                           input logic [7:0] ld, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = mo[7-i];
            wait_h();
            sclk = 1'b1;
            last_rise = cyc;
            mi[7-i] = miso;
            wait_h();
            sclk = 1'b0;
            if (ld_mid && i == 2) tb_load(ld);
        end
        wait_h();
    endtask

    task automatic cs_high();
        cs = 1'b1;
        mosi = 1'b0;
        wait_h();
        wait_h();
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_rv"}, n_rv, exp_rv);
        chk({tag, "_un"}, n_un, exp_un);
        chk({tag, "_rdy"}, tx_ready, !m_full);
        chk({tag, "_idle"}, miso, MISO_IDLE);
    endtask

    logic [7:0] cur, mi, mo, ld, last_mo;
    int nw;
    bit ldm;

    initial begin
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_miso", miso, MISO_IDLE);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_rx", rx_data, 8'h00);
        chk("rst_rv", rx_valid, 1'b0);
        chk("rst_un", tx_underrun, 1'b0);
        rst = 1'b0;
        wait_h();

        // Single byte
        tb_load(8'hA5);
        chk("s_ready_full", tx_ready, 1'b0);
        cs = 1'b0;
        consume(cur);
        do_word(8'h3C, 8, 1'b0, 8'h00, mi);
        exp_rv++;
        chk("s_miso", mi, cur);
        chk("s_lat", last_rv_cyc - last_rise, SYNC + 1);
        consume(cur);
        cs_high();
        chk("s_rx", rx_data, 8'h3C);
        check_counts("s");

        // Back-to-back, second word loaded during the first
        tb_load(8'h55);
        cs = 1'b0;
        consume(cur);
        do_word(8'h01, 8, 1'b1, 8'hAA, mi);
        exp_rv++;
        chk("b_miso0", mi, cur);
        chk("b_rx0", rx_data, 8'h01);
        consume(cur);
        do_word(8'hFE, 8, 1'b0, 8'h00, mi);
        exp_rv++;
        chk("b_miso1", mi, cur);
        consume(cur);
        cs_high();
        chk("b_rx1", rx_data, 8'hFE);
        check_counts("b");

        // Underrun at cs fall, refill mid-word
        chk("u_ready", tx_ready, 1'b1);
        cs = 1'b0;
        consume(cur);
        do_word(8'h96, 8, 1'b1, 8'h3A, mi);
        exp_rv++;
        chk("u_miso", mi, cur);
        consume(cur);
        cs_high();
        check_counts("u");

        // Abort after 5 bits; word loaded mid-word survives
        tb_load(8'h5A);
        cs = 1'b0;
        consume(cur);
        do_word(8'hF0, 5, 1'b1, 8'h77, mi);
        cs_high();
        check_counts("a");
        cs = 1'b0;
        consume(cur);
        do_word(8'h81, 8, 1'b0, 8'h00, mi);
        exp_rv++;
        chk("a_miso", mi, cur);
        consume(cur);
        cs_high();
        chk("a_rx", rx_data, 8'h81);
        check_counts("a2");

        // Load while full is ignored
        tb_load(8'h11);
        tb_load(8'h22);
        chk("l_ready", tx_ready, 1'b0);
        cs = 1'b0;
        consume(cur);
        do_word(8'h6D, 8, 1'b0, 8'h00, mi);
        exp_rv++;
        chk("l_miso", mi, cur);
        consume(cur);
        cs_high();
        chk("l_rx", rx_data, 8'h6D);
        check_counts("l");

        // Random transfers
        repeat (8) begin
            if ($urandom_range(0, 1) == 1) begin
                ld = 8'($urandom);
                tb_load(ld);
            end
            wait_h();
            nw = $urandom_range(1, 3);
            cs = 1'b0;
            consume(cur);
            for (int w = 0; w < nw; w++) begin
                mo  = 8'($urandom);
                ld  = 8'($urandom);
                ldm = 1'($urandom_range(0, 1));
                do_word(mo, 8, ldm, ld, mi);
                exp_rv++;
                chk("r_miso", mi, cur);
                last_mo = mo;
                consume(cur);
            end
            cs_high();
            chk("r_rx", rx_data, last_mo);
            check_counts("r");
        end

        // Reset mid-transfer
        tb_load(8'hE7);
        cs = 1'b0;
        consume(cur);
        do_word(8'hC3, 3, 1'b0, 8'h00, mi);
        chk("x_bits", mi & 8'hE0, cur & 8'hE0);
        rst = 1'b1;
        @(negedge clk);
        chk("x_miso", miso, MISO_IDLE);
        chk("x_ready", tx_ready, 1'b1);
        chk("x_rx", rx_data, 8'h00);
        chk("x_rv", rx_valid, 1'b0);
        chk("x_un", tx_underrun, 1'b0);
        cs = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        m_full = 1'b0;
        wait_h();
        rst = 1'b0;
        wait_h();
        tb_load(8'h9D);
        cs = 1'b0;
        consume(cur);
        do_word(8'h42, 8, 1'b0, 8'h00, mi);
        exp_rv++;
        chk("x2_miso", mi, cur);
        consume(cur);
        cs_high();
        chk("x2_rx", rx_data, 8'h42);
        check_counts("x2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the single-slave SPI link: the far end of the SPI master, with the same `clk` and `cs` (active-low) conventions. It oversamples `sclk`, `cs` and `mosi` in the system clock domain and deserialises MOSI into parallel words for local logic. It also serialises a locally loaded word onto MISO. It operates in SPI mode 0 (CPOL=0, CPHA=0), MSB first, and supports back-to-back words within one `cs` assertion.

## Interface
- `DATA_W`, default 8: word width in bits (≥ 2).
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `cs`, `mosi` (≥ 2).
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock from master (asynchronous to `clk`).
- `cs`  in  1  chip select, active low.
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master.
- `tx_data`  in  DATA_W  word to send on the next transfer.
- `tx_load`  in  1  loads `tx_data` when `tx_ready`=1.
- `tx_ready`  out  1  TX holding buffer empty.
- `rx_data`  out  DATA_W  last complete received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `tx_underrun`  out  1  one-cycle pulse: a word started with an empty TX buffer.

## Operation
- **Reset values:**
  - Sync chains: `sclk`=0, `cs`=1, `mosi`=0.
  - `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0.
  - State IDLE, bit counter 0.
- **Edge detection:** rise and fall of synchronised `sclk` and `cs` come from the last sync stage compared with a one-cycle-delayed copy.
- **TX holding buffer:** `tx_load` with `tx_ready`=1 captures `tx_data` and clears `tx_ready`. `tx_load` with `tx_ready`=0 is ignored and the buffer is unchanged. The buffer is consumed when it is copied to the TX shifter, which sets `tx_ready`.
- **IDLE:** `cs` falling edge moves the block to ACTIVE and sets bit_cnt=0.
  - If the buffer is full, the TX shifter loads the buffered word.
  - Otherwise the shifter loads 0 and `tx_underrun` pulses.
  - `miso` presents shifter[DATA_W-1] in the same cycle.
- **ACTIVE, `sclk` rise:**
  - The RX shifter shifts left and takes synchronised `mosi` into bit 0.
  - bit_cnt increments.
  - At bit_cnt=DATA_W-1: `rx_data` takes the completed word, `rx_valid` pulses, bit_cnt wraps to 0 and word_done is set.
- **ACTIVE, `sclk` fall:**
  - With bit_cnt≠0: the TX shifter shifts left and `miso` takes the new MSB.
  - With bit_cnt=0 and word_done=1: the next word loads from the buffer (empty → 0 and `tx_underrun` pulse), then word_done clears.
- **ACTIVE, `cs` rising edge (including mid-word):**
  - Return to IDLE, clear bit_cnt and word_done.
  - A partial RX word is discarded with no `rx_valid`.
  - A buffered TX word that was not consumed is kept.
  - `miso` returns to its idle value.
- **Simultaneous events:**
  - A `cs` rise outranks an `sclk` edge in the same cycle.
  - `tx_load` in the same cycle as a buffer consume: the consume happens first and the new word is accepted.
- **Async `rst` mid-transfer:** immediate return to reset values. The master sees the idle `miso` value.

## Timing
- Synchronisation latency: a pin edge acts on internal state at the (SYNC_STAGES+1)th `clk` rising edge after it.
- `rx_valid` is high for exactly one cycle, SYNC_STAGES+1 `clk` edges after the last `sclk` rising edge of a word.
- `miso` updates SYNC_STAGES+1 `clk` edges after a `sclk` falling edge or `cs` falling edge.
- Constraints on the master:
  - `sclk` high and low times ≥ SYNC_STAGES+2 `clk` periods.
  - `cs` setup before the first `sclk` rise ≥ SYNC_STAGES+2 `clk` periods.
  - `tx_data` must be loaded before the `cs` fall, or before the last falling edge of the previous word.

## Configuration
- **`SPI_SLAVE_MISO_TRISTATE_EN` defined:** `miso` is 1'bz in IDLE and in reset, and is driven only in ACTIVE, for sharing the MISO line.
- **Not defined:** `miso` is driven 0 in IDLE and in reset.

## Test plan
- **Single byte:** load `tx_data`=8'hA5, then master sends 8'h3C with `cs` low for 8 `sclk` → `rx_data`=8'h3C with one `rx_valid` pulse; master samples 8'hA5; `tx_ready` returns to 1.
- **Back-to-back:** two words 8'h01, 8'hFE in one `cs` assertion, with 8'h55 preloaded and 8'hAA loaded after the first consume → two `rx_valid` pulses; MISO carries 8'h55 then 8'hAA.
- **Underrun:** `cs` falls with `tx_ready`=1 → `tx_underrun` pulses once and MISO sends 8'h00.
- **Abort:** `cs` rises after 5 `sclk` → no `rx_valid`; the next full transfer of 8'h81 is received correctly.
- **Load while full:** `tx_load` 8'h11 then 8'h22 before `cs` → 8'h11 is sent and 8'h22 is ignored.
- **Reset mid-transfer:** `rst` asserted after 3 bits → all outputs at reset values; `miso`=z with the macro defined, 0 without it.
